bomb_scheduler: RTL

- Shared bomb-slot manager for the two-player tile game. Sits between the two player movers and the tile renderer.
- Arbitrates bomb-placement pulses from player A and player B into a fixed pool of bomb slots.
- Sequences each bomb through a fuse countdown and a blast phase.
- Publishes the walkability map consumed by the player movers and a blast map used by the renderer and for hit detection.

---
 rtl/bomb_pkg.sv | 25 ++
 rtl/bomb_scheduler_slot.sv | 68 ++++++
 rtl/bomb_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bomb_pkg.sv
// Shared types and helpers for the bomb scheduler: slot state encoding,
// arbitration pointer encoding, map width and tile indexing.
package bomb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_BLAST = 2'd2
  } slot_state_e;

  typedef enum logic {
    PL_A = 1'b0,
    PL_B = 1'b1
  } player_e;

  localparam int unsigned HMAX_DEF = 9;
  localparam int unsigned VMAX_DEF = 5;
  localparam int unsigned MAP_W    = (HMAX_DEF + 1) * (VMAX_DEF + 1) + 1;

  function automatic int unsigned tile_idx(input logic [3:0] h, input logic [3:0] v,
                                           input int unsigned hmax);
    return (hmax + 1) * 32'(v) + 32'(h);
  endfunction

endpackage

// File: rtl/bomb_scheduler_slot.sv
// One bomb slot: IDLE -> ARMED (fuse countdown) -> BLAST -> IDLE, with its
// tile registers. done_o flags the tick on which the slot returns to IDLE.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int unsigned CW         = 2,
  parameter int unsigned FUSETICKS  = 3,
  parameter int unsigned BLASTTICKS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_i,
  input  logic        alloc_i,
  input  logic [3:0]  h_i,
  input  logic [3:0]  v_i,
  input  logic        chain_i,
  output slot_state_e state_o,
  output logic [3:0]  h_o,
  output logic [3:0]  v_o,
  output logic        done_o
);

  slot_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    h_q;
  logic [3:0]    v_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (alloc_i) begin
            state_q <= S_ARMED;
            cnt_q   <= CW'(FUSETICKS - 1);
            h_q     <= h_i;
            v_q     <= v_i;
          end
        end
        S_ARMED: begin
          if (chain_i || (tick_i && cnt_q == '0)) begin
            state_q <= S_BLAST;
            cnt_q   <= CW'(BLASTTICKS - 1);
          end else if (tick_i) begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_BLAST: begin
          if (tick_i) begin
            if (cnt_q == '0) state_q <= S_IDLE;
            else             cnt_q   <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign h_o     = h_q;
  assign v_o     = v_q;
  assign done_o  = (state_q == S_BLAST) && tick_i && (cnt_q == '0);

endmodule

// File: rtl/bomb_scheduler.sv
// Shared bomb-slot manager: arbitrates A/B placement pulses into NUMSLOT slots
// and publishes walkability and blast maps. Optional macro: CHAIN_REACTION_EN.
module bomb_scheduler
  import bomb_pkg::*;
#(
  parameter int unsigned NUMSLOT    = 4,
  parameter int unsigned HMAXTILE   = HMAX_DEF,
  parameter int unsigned VMAXTILE   = VMAX_DEF,
  parameter int unsigned TICKW      = 24,
  parameter int unsigned FUSETICKS  = 3,
  parameter int unsigned BLASTTICKS = 1,
  parameter int unsigned RADIUS     = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 reqA,
  input  logic [3:0]                           posAh,
  input  logic [3:0]                           posAv,
  input  logic                                 reqB,
  input  logic [3:0]                           posBh,
  input  logic [3:0]                           posBv,
  input  logic [(HMAXTILE+1)*(VMAXTILE+1):0]   wallMap,
  output logic                                 grantA,
  output logic                                 grantB,
  output logic                                 rejectA,
  output logic                                 rejectB,
  output logic [(HMAXTILE+1)*(VMAXTILE+1):0]   walkAble,
  output logic [(HMAXTILE+1)*(VMAXTILE+1):0]   blastMap,
  output logic [3:0]                           numFree
);

  localparam int unsigned MW   = (HMAXTILE + 1) * (VMAXTILE + 1) + 1;
  localparam int unsigned CMAX = (FUSETICKS > BLASTTICKS) ? FUSETICKS : BLASTTICKS;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam logic [MW-1:0] ONE = MW'(1);

  logic [TICKW-1:0] presc_q;
  logic             pendA_q, pendB_q;
  player_e          prio_q;
  logic             grantA_q, grantB_q, rejectA_q, rejectB_q;
  logic [3:0]       numFree_q;

  slot_state_e      st [NUMSLOT];
  logic [3:0]       sh [NUMSLOT];
  logic [3:0]       sv [NUMSLOT];
  logic [NUMSLOT-1:0] alloc, done, chain;

  logic          tick;
  logic          candA, candB, serveA, serveB, svc, ok;
  logic [3:0]    tgt_h, tgt_v;
  logic [3:0]    numFree_d;
  logic [MW-1:0] blast_d, walk_d;

  assign tick = &presc_q;

  for (genvar g = 0; g < NUMSLOT; g++) begin : g_slot
    bomb_slot #(
      .CW         (CW),
      .FUSETICKS  (FUSETICKS),
      .BLASTTICKS (BLASTTICKS)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .tick_i  (tick),
      .alloc_i (alloc[g]),
      .h_i     (tgt_h),
      .v_i     (tgt_v),
      .chain_i (chain[g]),
      .state_o (st[g]),
      .h_o     (sh[g]),
      .v_o     (sv[g]),
      .done_o  (done[g])
    );
  end

  always_comb begin
    logic armed_hit, found;
    candA  = reqA | pendA_q;
    candB  = reqB | pendB_q;
    serveA = candA & (~candB | (prio_q == PL_A));
    serveB = candB & (~candA | (prio_q == PL_B));
    svc    = serveA | serveB;
    tgt_h  = serveB ? posBh : posAh;
    tgt_v  = serveB ? posBv : posAv;
    armed_hit = 1'b0;
    found     = 1'b0;
    alloc     = '0;
    for (int unsigned s = 0; s < NUMSLOT; s++) begin
      if (st[s] == S_ARMED && sh[s] == tgt_h && sv[s] == tgt_v) armed_hit = 1'b1;
      if (!found && st[s] == S_IDLE) begin
        alloc[s] = 1'b1;
        found    = 1'b1;
      end
    end
    ok = found & ~armed_hit;
    if (!(svc && ok)) alloc = '0;
    // Free count after this edge: idle slots not being taken, plus slots retiring now
    numFree_d = '0;
    for (int unsigned s = 0; s < NUMSLOT; s++) begin
      if ((st[s] == S_IDLE && !alloc[s]) || done[s]) numFree_d = numFree_d + 4'd1;
    end
  end

  always_comb begin
    blast_d = '0;
    walk_d  = wallMap;
    for (int unsigned s = 0; s < NUMSLOT; s++) begin
      int unsigned hh, vv, c;
      hh = 32'(sh[s]);
      vv = 32'(sv[s]);
      c  = tile_idx(sh[s], sv[s], HMAXTILE);
      if (hh <= HMAXTILE && vv <= VMAXTILE) begin
        if (st[s] == S_ARMED) walk_d = walk_d & ~(ONE << c);
        if (st[s] == S_BLAST) begin
          for (int unsigned k = 0; k <= RADIUS; k++) begin
            if (hh + k <= HMAXTILE) blast_d = blast_d | (ONE << (c + k));
            if (hh >= k)            blast_d = blast_d | (ONE << (c - k));
            if (vv + k <= VMAXTILE) blast_d = blast_d | (ONE << (c + k * (HMAXTILE + 1)));
            if (vv >= k)            blast_d = blast_d | (ONE << (c - k * (HMAXTILE + 1)));
          end
        end
      end
    end
  end

`ifdef CHAIN_REACTION_EN
  always_comb begin
    chain = '0;
    for (int unsigned s = 0; s < NUMSLOT; s++) begin
      if (st[s] == S_ARMED && 32'(sh[s]) <= HMAXTILE && 32'(sv[s]) <= VMAXTILE)
        chain[s] = |(blast_d & (ONE << tile_idx(sh[s], sv[s], HMAXTILE)));
    end
  end
`else
  assign chain = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q   <= '0;
      pendA_q   <= 1'b0;
      pendB_q   <= 1'b0;
      prio_q    <= PL_A;
      grantA_q  <= 1'b0;
      grantB_q  <= 1'b0;
      rejectA_q <= 1'b0;
      rejectB_q <= 1'b0;
      numFree_q <= 4'(NUMSLOT);
    end else begin
      presc_q   <= presc_q + TICKW'(1);
      pendA_q   <= candA & ~serveA;
      pendB_q   <= candB & ~serveB;
      grantA_q  <= serveA & ok;
      grantB_q  <= serveB & ok;
      rejectA_q <= serveA & ~ok;
      rejectB_q <= serveB & ~ok;
      if (svc && ok) prio_q <= serveA ? PL_B : PL_A;
      numFree_q <= numFree_d;
    end
  end

  assign grantA   = grantA_q;
  assign grantB   = grantB_q;
  assign rejectA  = rejectA_q;
  assign rejectB  = rejectB_q;
  assign numFree  = numFree_q;
  assign walkAble = walk_d;
  assign blastMap = blast_d;

endmodule
